// File: rtl/spoly_pkg.sv
// Shared definitions for the short-polynomial sequencer: FSM state encoding,
// ternary coefficient encodings, default geometry and the RAM-word to
// coefficient mapping.
package spoly_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SORT_REQ  = 3'd2,
        ST_SORT_WAIT = 3'd3,
        ST_READ      = 3'd4,
        ST_EMIT      = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    // Two's complement ternary coefficients
    localparam logic [1:0] COEF_NEG  = 2'b11;
    localparam logic [1:0] COEF_ZERO = 2'b00;
    localparam logic [1:0] COEF_POS  = 2'b01;

    localparam int SPOLY_P_DEF  = 757;
    localparam int SPOLY_W_DEF  = 286;
    localparam int SPOLY_DW_DEF = 32;
    localparam int SPOLY_AW_DEF = 10;

    // Stored low bits 00/01/10 become -1/0/+1. The unused code 11 falls
    // through the same subtraction to 10 on purpose; no trap is raised.
    function automatic logic [1:0] coef_from_rdata(input logic [1:0] lo);
        return lo - 2'd1;
    endfunction

endpackage

// File: rtl/spoly_seq_ctrl_if.sv
// Handshake bundle between the sequencer and its neighbours: RNG stream,
// shared coefficient RAM, external sorter and coefficient consumer.
// master = sequencer side, slave = environment side.
interface spoly_seq_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          rnd_valid;
    logic [DW-1:0] rnd_data;
    logic          rnd_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          sort_start;
    logic          sort_done;
    logic          coef_valid;
    logic [1:0]    coef_data;
    logic          coef_ready;

    modport master (
        input  rnd_valid, rnd_data, mem_rdata, sort_done, coef_ready,
        output rnd_ready, mem_we, mem_addr, mem_wdata, sort_start,
               coef_valid, coef_data
    );

    modport slave (
        output rnd_valid, rnd_data, mem_rdata, sort_done, coef_ready,
        input  rnd_ready, mem_we, mem_addr, mem_wdata, sort_start,
               coef_valid, coef_data
    );
endinterface

// File: rtl/spoly_mask.sv
// Weight mask for a random word: the first W positions get bit0 cleared
// (low bits 00/10 -> nonzero coefficient), the rest get low bits forced to 01
// (zero coefficient). Purely combinational.
// Ports: idx_i word position, word_i raw random word, word_o masked word.
module spoly_mask #(
    parameter int W  = 286,
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic [AW-1:0] idx_i,
    input  logic [DW-1:0] word_i,
    output logic [DW-1:0] word_o
);
    // W must fit in AW bits
    localparam logic [AW-1:0] W_IDX  = AW'(W);
    localparam logic [DW-1:0] CLR_B0 = ~DW'(1);
    localparam logic [DW-1:0] CLR_B1 = ~DW'(3);
    localparam logic [DW-1:0] SET_B0 = DW'(1);

    assign word_o = (idx_i < W_IDX) ? (word_i & CLR_B0)
                                    : ((word_i & CLR_B1) | SET_B0);
endmodule

// File: rtl/spoly_seq_ctrl.sv
// Sequencer for weight-W ternary polynomials: loads P masked random words into
// the coefficient RAM, kicks the external sorter, then streams the sorted
// words back out as ternary coefficients (at most one per two cycles).
// Ports: clk/rst_n (async active-low), start/busy/done level control,
// bus = RNG, RAM, sorter and coefficient handshakes, weight_err optional.
// Optional feature macro: SPOLY_WEIGHT_CHECK_EN (emitted-weight check).
module spoly_seq_ctrl
    import spoly_pkg::*;
#(
    parameter int P  = SPOLY_P_DEF,
    parameter int W  = SPOLY_W_DEF,
    parameter int DW = SPOLY_DW_DEF,
    parameter int AW = SPOLY_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              weight_err,
    spoly_seq_ctrl_if.master  bus
);
    localparam logic [AW-1:0] IDX_LAST = AW'(P - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    rdata_q;
    logic          first_q;

    logic [DW-1:0] masked_word;
    logic [1:0]    coef_cur;
    logic          coef_hs;

    logic          rnd_ready_c, mem_we_c, sort_start_c, coef_valid_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic [1:0]    coef_data_c;

    spoly_mask #(.W(W), .DW(DW), .AW(AW)) u_mask (
        .idx_i  (idx_q),
        .word_i (bus.rnd_data),
        .word_o (masked_word)
    );

    // RAM data arrives in the first EMIT cycle; it is used directly then and
    // held in rdata_q afterwards because mem_addr returns to 0 in EMIT and
    // the RAM output would otherwise move during a stall.
    assign coef_cur = coef_from_rdata(first_q ? bus.mem_rdata[1:0] : rdata_q);
    assign coef_hs  = (state_q == ST_EMIT) && bus.coef_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rnd_ready_c  = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        sort_start_c = 1'b0;
        coef_valid_c = 1'b0;
        coef_data_c  = COEF_ZERO;
        busy         = (state_q != ST_IDLE);
        done         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                rnd_ready_c = 1'b1;
                mem_addr_c  = idx_q;
                if (bus.rnd_valid) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = masked_word;
                    if (idx_q == IDX_LAST) state_d = ST_SORT_REQ;
                    else                   idx_d   = idx_q + AW'(1);
                end
            end
            ST_SORT_REQ: begin
                sort_start_c = 1'b1;
                state_d      = ST_SORT_WAIT;
            end
            ST_SORT_WAIT: begin
                if (bus.sort_done) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                end
            end
            ST_READ: begin
                mem_addr_c = idx_q;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                coef_valid_c = 1'b1;
                coef_data_c  = coef_cur;
                if (bus.coef_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rdata_q <= 2'b00;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= (state_q == ST_READ);
            if (first_q) rdata_q <= bus.mem_rdata[1:0];
        end
    end

    assign bus.rnd_ready  = rnd_ready_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.sort_start = sort_start_c;
    assign bus.coef_valid = coef_valid_c;
    assign bus.coef_data  = coef_data_c;

`ifdef SPOLY_WEIGHT_CHECK_EN
    localparam logic [AW-1:0] W_CNT = AW'(W);

    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          werr_q, werr_d;

    always_comb begin
        wcnt_d = wcnt_q;
        werr_d = werr_q;
        if (state_q == ST_IDLE && start) begin
            wcnt_d = '0;
            werr_d = 1'b0;
        end else begin
            if (coef_hs && coef_cur != COEF_ZERO) wcnt_d = wcnt_q + AW'(1);
            // Compare using the count that includes the final coefficient
            if (state_q == ST_EMIT && state_d == ST_DONE) werr_d = (wcnt_d != W_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            werr_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            werr_q <= werr_d;
        end
    end

    assign weight_err = werr_q;
`else
    assign weight_err = 1'b0;
`endif

endmodule

// File: tb/tb_spoly_seq_ctrl.sv
module tb_spoly_seq_ctrl;
    localparam int P  = 8;
    localparam int W  = 3;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, weight_err;

    spoly_seq_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    spoly_seq_ctrl #(.P(P), .W(W), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .weight_err (weight_err),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- environment: RAM with one-cycle read latency ----------
    logic [DW-1:0] ram [P];
    initial begin
        logic [AW-1:0] a;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            a = bus.mem_addr;
            if (bus.mem_we === 1'b1 && a < AW'(P)) ram[a] = bus.mem_wdata;
            #1 bus.mem_rdata = (a < AW'(P)) ? ram[a] : '0;
        end
    end

    // ---------------- environment: sorter, answers 5 cycles after request ---
    int            sort_mode = 0;   // 0: ascending sort, 1: overwrite with pat
    logic [DW-1:0] pat [P];
    initial begin
        logic [DW-1:0] q [$];
        bus.sort_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.sort_start === 1'b1) begin
                repeat (5) @(negedge clk);
                q.delete();
                for (int i = 0; i < P; i++) q.push_back(ram[i]);
                if (sort_mode == 0) q.sort();
                for (int i = 0; i < P; i++) ram[i] = (sort_mode == 0) ? q[i] : pat[i];
                bus.sort_done = 1'b1;
                @(negedge clk);
                bus.sort_done = 1'b0;
            end
        end
    end

    // ---------------- reference model --------------------------------------
    logic [DW-1:0] words_g [P];

    function automatic logic [DW-1:0] ref_mask(input int pos, input logic [DW-1:0] w);
        if (pos < W) return w & 32'hFFFF_FFFE;
        return (w & 32'hFFFF_FFFC) | 32'h1;
    endfunction

    // ternary value = stored low field minus one, kept to two bits
    function automatic logic [1:0] ref_coef(input logic [DW-1:0] w);
        int v;
        logic [1:0] r;
        v = int'(w[1:0]) - 1;
        r = v[1:0];
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_werr"}, weight_err, 0);
        chk({tag, "_handshake_outs"},
            {bus.rnd_ready, bus.mem_we, bus.sort_start, bus.coef_valid, bus.coef_data}, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    // vmode: 0 valid always, 1 toggle, 2 random
    // rmode: 0 ready always, 1 first coef stalled 4 cycles, 2 random
    // smode: sorter mode; abort_at >= 0 returns after that many words loaded
    task automatic run(input string tag, input int vmode, input int rmode,
                       input int smode, input int abort_at, input bit hold_start);
        logic [DW-1:0] exp_wr [P];
        logic [DW-1:0] q [$];
        logic [1:0]    exp_coef [P];
        logic [1:0]    pend_dat;
        int  k, nw, nc, nz, stall, spulse;
        bit  pend, seen_done, tog, v, exp_err;

        for (int i = 0; i < P; i++) exp_wr[i] = ref_mask(i, words_g[i]);
        q.delete();
        for (int i = 0; i < P; i++) q.push_back(exp_wr[i]);
        if (smode == 0) q.sort();
        nz = 0;
        for (int i = 0; i < P; i++) begin
            exp_coef[i] = ref_coef(smode == 0 ? q[i] : pat[i]);
            if (exp_coef[i] != 2'b00) nz++;
        end
        sort_mode = smode;
        k = 0; nw = 0; nc = 0; stall = 0; spulse = 0;
        pend = 0; seen_done = 0; tog = 1; pend_dat = 2'b00;

        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (abort_at >= 0 && k >= abort_at) begin
                bus.rnd_valid = 1'b0;
                #1 chk({tag, "_abort_idx"}, bus.mem_addr, AW'(abort_at));
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.rnd_valid = (k < P) ? v : 1'b0;
            bus.rnd_data  = (k < P) ? words_g[k] : $urandom;
            case (rmode)
                0:       bus.coef_ready = 1'b1;
                1:       bus.coef_ready = (nc > 0) || (stall >= 4);
                default: bus.coef_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (bus.mem_we) begin
                if (nw < P) begin
                    chk({tag, "_wr_addr"}, bus.mem_addr, nw);
                    chk({tag, "_wr_data"}, bus.mem_wdata, exp_wr[nw]);
                end
                nw++;
            end
            if (!bus.rnd_valid) chk({tag, "_no_write_idle"}, bus.mem_we, 0);
            if (bus.rnd_valid && bus.rnd_ready) k++;
            if (bus.sort_start) spulse++;
            if (bus.coef_valid) begin
                if (pend) chk({tag, "_coef_hold"}, bus.coef_data, pend_dat);
                if (bus.coef_ready) begin
                    if (nc < P) chk({tag, "_coef"}, bus.coef_data, exp_coef[nc]);
                    nc++;
                    pend = 0;
                end else begin
                    pend = 1;
                    pend_dat = bus.coef_data;
                    if (nc == 0) stall++;
                end
            end else if (pend) begin
                chk({tag, "_coef_valid_dropped"}, bus.coef_valid, 1);
                pend = 0;
            end
            if (done) begin
                seen_done = 1;
                chk({tag, "_done_after_last"}, nc, P);
            end
        end
        chk({tag, "_done_seen"}, seen_done, 1);
        chk({tag, "_n_writes"}, nw, P);
        chk({tag, "_n_coefs"}, nc, P);
        chk({tag, "_sort_pulses"}, spulse, 1);
`ifdef SPOLY_WEIGHT_CHECK_EN
        exp_err = (nz != W);
`else
        exp_err = 1'b0;
`endif
        chk({tag, "_weight_err"}, weight_err, exp_err);
        if (hold_start) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1 chk({tag, "_hold_done"}, {busy, done}, 2'b11);
            end
            start = 1'b0;
        end
        @(negedge clk);
        #1 chk({tag, "_back_idle"}, {busy, done}, 2'b00);
        chk({tag, "_werr_held"}, weight_err, exp_err);
    endtask

    task automatic set_words_random();
        for (int i = 0; i < P; i++) words_g[i] = $urandom;
    endtask

    initial begin
        bus.rnd_valid  = 1'b0;
        bus.rnd_data   = '0;
        bus.coef_ready = 1'b0;
        for (int i = 0; i < P; i++) begin ram[i] = '0; pat[i] = '0; end
        repeat (3) @(negedge clk);
        #1 check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1 check_quiet("idle");

        // all-ones words: 3 x FFFF_FFFE then 5 x FFFF_FFFD; sorted -> 0 x5, +1 x3
        for (int i = 0; i < P; i++) words_g[i] = 32'hFFFF_FFFF;
        run("ones", 0, 0, 0, -1, 1'b0);

        // sorter leaves 2,2,1,1,1,1,1,0 -> +1,+1,0,0,0,0,0,-1
        set_words_random();
        for (int i = 0; i < P; i++) pat[i] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b01};
        pat[0][1:0] = 2'b10; pat[1][1:0] = 2'b10; pat[7][1:0] = 2'b00;
        run("pattern", 1, 1, 1, -1, 1'b0);

        // same with one nonzero replaced by a zero coefficient -> weight 2
        set_words_random();
        pat[1][1:0] = 2'b01;
        run("weight_short", 2, 0, 1, -1, 1'b0);

        // random words, random handshakes, random sorted or raw patterns
        for (int r = 0; r < 6; r++) begin
            set_words_random();
            for (int i = 0; i < P; i++) pat[i] = $urandom;
            run("random", 2, 2, r % 2, -1, 1'b0);
        end

        // abort mid-LOAD by reset, then a clean run holding start high
        set_words_random();
        run("abort", 0, 0, 0, 4, 1'b0);
        rst_n = 1'b0;
        #1 check_quiet("mid_load_reset");
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_quiet("mid_load_reset_hold");
        rst_n = 1'b1;
        set_words_random();
        run("after_reset", 1, 2, 0, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
